// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
package dmem_resp_pkg;

    // Responder FSM states: idle/accepting, inserting wait states, presenting the response
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Low address bits that must be zero for a word-aligned access
    localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

    // An access is rejected when it is not word aligned or falls past the last stored byte
    function automatic logic is_err(input logic [31:0] addr, input logic [31:0] depth);
        logic [33:0] limit;
        limit = {2'b00, depth} << 2;
        return ((addr[1:0] & ADDR_ALIGN_MASK) != 2'b00) || ({2'b00, addr} >= limit);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU MEM stage (master) and the data memory (slave).
// Signal suffixes are from the responder's point of view.
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        stall_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, stall_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, stall_o
    );
endinterface

// File: rtl/dmem_array.sv
// Word storage for the responder: synchronous write, registered read, synchronous clear.
// The read register returns zero whenever no read is requested, so the responder's data
// output is zero outside the response cycle without extra gating.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned IDX_W       = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Select the word being read, or zero when this edge is not a load commit
    always_comb begin
        rdata_d = '0;
        if (rd_en_i) begin
            rdata_d = mem_q[idx_i];
        end
    end

    // Storage and read register; reset wins over a coincident write
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[idx_i] <= wdata_i;
            end
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU MEM stage: accepts one request at a time, inserts
// WAIT_CYCLES wait states, then presents a one-cycle response while stalling the pipeline.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    dmem_responder_if.slave  bus
);
    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAST_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;

    logic        commit;
    logic        commit_we;
    logic [31:0] commit_addr;
    logic [31:0] commit_wdata;
    logic        commit_err;
    logic        wr_en;
    logic        rd_en;

    // Next-state logic: handshake, wait-state counting and the commit decision.
    // With zero wait states the commit happens on the accept edge, so the live
    // request inputs are used instead of the (not yet loaded) request latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    we_d    = bus.req_we_i;
                    addr_d  = bus.req_addr_i;
                    wdata_d = bus.req_wdata_i;
                    cnt_d   = '0;
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        commit_we    = (state_q == S_IDLE) ? bus.req_we_i    : we_q;
        commit_addr  = (state_q == S_IDLE) ? bus.req_addr_i  : addr_q;
        commit_wdata = (state_q == S_IDLE) ? bus.req_wdata_i : wdata_q;
        commit       = (state_d == S_RESP) && (state_q != S_RESP);
        commit_err   = is_err(commit_addr, 32'(DEPTH_WORDS));
        wr_en        = commit && commit_we && !commit_err;
        rd_en        = commit && !commit_we && !commit_err;

        ready_d      = (state_d == S_IDLE);
        resp_valid_d = commit;
        resp_err_d   = commit && commit_err;
    end

    // State, request latch and registered handshake/response flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en_i (wr_en),
        .rd_en_i (rd_en),
        .idx_i   (commit_addr[IDX_W+1:2]),
        .wdata_i (commit_wdata),
        .rdata_o (bus.resp_rdata_o)
    );

    assign bus.req_ready_o  = ready_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_err_o   = resp_err_q;
    assign bus.stall_o      = ((state_q == S_IDLE) && bus.req_valid_i) || (state_q == S_WAIT);
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;
    logic clk;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(2)) dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls the whole run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    // Step to 1 time unit after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive the request side of one of the two instances
    task automatic drive(input bit use0, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (use0) begin
            bus0.req_valid_i = v; bus0.req_we_i = we; bus0.req_addr_i = a; bus0.req_wdata_i = d;
        end else begin
            bus2.req_valid_i = v; bus2.req_we_i = we; bus2.req_addr_i = a; bus2.req_wdata_i = d;
        end
    endtask

    // Run one access like the CPU would: hold the request until the response cycle.
    // Cycle 1 is the cycle in which the request is first presented.
    task automatic do_access(input bit use0, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata,
                             output logic err, output int stalls, output int resp_cyc);
        stalls   = 0;
        resp_cyc = -1;
        rdata    = 'x;
        err      = 'x;
        drive(use0, 1'b1, we, addr, wdata);
        for (int c = 1; c <= 30; c++) begin
            #1;
            if (use0 ? bus0.stall_o : bus2.stall_o) stalls++;
            if (use0 ? bus0.resp_valid_o : bus2.resp_valid_o) begin
                rdata    = use0 ? bus0.resp_rdata_o : bus2.resp_rdata_o;
                err      = use0 ? bus0.resp_err_o : bus2.resp_err_o;
                resp_cyc = c;
                break;
            end
            next_cycle();
        end
        drive(use0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int st; int rc;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        vectors++; if (bus2.req_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready2: got %b expected 1", bus2.req_ready_o); end
        vectors++; if (bus2.stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall2: got %b expected 0", bus2.stall_o); end
        vectors++; if (bus2.resp_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rvalid2: got %b expected 0", bus2.resp_valid_o); end
        vectors++; if (bus2.resp_rdata_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata2: got %h expected 0", bus2.resp_rdata_o); end
        vectors++; if (bus2.resp_err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err2: got %b expected 0", bus2.resp_err_o); end
        vectors++; if (bus0.req_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready0: got %b expected 1", bus0.req_ready_o); end
        vectors++; if (bus0.resp_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rvalid0: got %b expected 0", bus0.resp_valid_o); end
        next_cycle();
        do_access(1'b0, 1'b0, 32'h0000_0000, 32'h0, rd, er, st, rc);
        vectors++; if (rd !== 32'h0 || er !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_load_0x0: got %h/%b expected 0/0", rd, er); end
        do_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, rd, er, st, rc);
        vectors++; if (rd !== 32'h0 || er !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_load_0x10: got %h/%b expected 0/0", rd, er); end
        do_access(1'b0, 1'b0, 32'h0000_01FC, 32'h0, rd, er, st, rc);
        vectors++; if (rd !== 32'h0 || er !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_load_0x1fc: got %h/%b expected 0/0", rd, er); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int st; int rc;
        do_access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, st, rc);
        vectors++; if (st !== 3) begin miscompares++; $display("[TB] FAIL store_stall_cycles: got %0d expected 3", st); end
        vectors++; if (rc !== 4) begin miscompares++; $display("[TB] FAIL store_resp_cycle: got %0d expected 4", rc); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("[TB] FAIL store_err: got %b expected 0", er); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL store_rdata: got %h expected 0", rd); end
        vectors++; if (bus2.resp_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL store_pulse_width: got %b expected 0", bus2.resp_valid_o); end
        do_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, rd, er, st, rc);
        vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL load_rdata: got %h expected deadbeef", rd); end
        vectors++; if (rc !== 4) begin miscompares++; $display("[TB] FAIL load_resp_cycle: got %0d expected 4", rc); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("[TB] FAIL load_err: got %b expected 0", er); end
        vectors++; if (bus2.resp_rdata_o !== 32'h0) begin miscompares++; $display("[TB] FAIL rdata_after_resp: got %h expected 0", bus2.resp_rdata_o); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic er; int st; int rc;
        do_access(1'b1, 1'b0, 32'h0000_0000, 32'h0, rd, er, st, rc);
        vectors++; if (rc !== 2) begin miscompares++; $display("[TB] FAIL w0_load_resp_cycle: got %0d expected 2", rc); end
        vectors++; if (st !== 1) begin miscompares++; $display("[TB] FAIL w0_load_stall_cycles: got %0d expected 1", st); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL w0_load_rdata: got %h expected 0", rd); end
        do_access(1'b1, 1'b1, 32'h0000_01FC, 32'h1234_5678, rd, er, st, rc);
        vectors++; if (er !== 1'b0 || rc !== 2) begin miscompares++; $display("[TB] FAIL w0_store_top: got err %b cyc %0d expected 0 2", er, rc); end
        do_access(1'b1, 1'b0, 32'h0000_01FC, 32'h0, rd, er, st, rc);
        vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("[TB] FAIL w0_load_top: got %h expected 12345678", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int st; int rc;
        do_access(1'b0, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, rd, er, st, rc);
        vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL err_misaligned_store: got %b/%h expected 1/0", er, rd); end
        vectors++; if (rc !== 4) begin miscompares++; $display("[TB] FAIL err_resp_cycle: got %0d expected 4", rc); end
        do_access(1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, rd, er, st, rc);
        vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL err_range_store: got %b/%h expected 1/0", er, rd); end
        do_access(1'b0, 1'b0, 32'h0000_0200, 32'h0, rd, er, st, rc);
        vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL err_range_load: got %b/%h expected 1/0", er, rd); end
        do_access(1'b0, 1'b0, 32'h0000_0011, 32'h0, rd, er, st, rc);
        vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL err_misaligned_load: got %b/%h expected 1/0", er, rd); end
        do_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, rd, er, st, rc);
        vectors++; if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL err_kept_0x10: got %b/%h expected 0/deadbeef", er, rd); end
        do_access(1'b0, 1'b0, 32'h0000_0000, 32'h0, rd, er, st, rc);
        vectors++; if (er !== 1'b0 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL err_kept_0x0: got %b/%h expected 0/0", er, rd); end
        do_access(1'b0, 1'b0, 32'h0000_01FC, 32'h0, rd, er, st, rc);
        vectors++; if (er !== 1'b0 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL err_last_word: got %b/%h expected 0/0", er, rd); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int st; int rc; int seen;
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055);
        next_cycle();
        vectors++; if (bus2.stall_o !== 1'b1) begin miscompares++; $display("[TB] FAIL midwait_stall: got %b expected 1", bus2.stall_o); end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus2.resp_valid_o) seen++;
            next_cycle();
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("[TB] FAIL midwait_no_resp: got %0d expected 0", seen); end
        vectors++; if (bus2.req_ready_o !== 1'b1 || bus2.stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL midwait_idle: got ready %b stall %b expected 1 0", bus2.req_ready_o, bus2.stall_o); end
        do_access(1'b0, 1'b0, 32'h0000_0020, 32'h0, rd, er, st, rc);
        vectors++; if (rd !== 32'h0 || rc !== 4) begin miscompares++; $display("[TB] FAIL midwait_load_0x20: got %h cyc %0d expected 0 4", rd, rc); end

        do_access(1'b0, 1'b1, 32'h0000_0028, 32'h1111_1111, rd, er, st, rc);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0024, 32'h0000_0077);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus2.resp_valid_o) seen++;
            next_cycle();
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("[TB] FAIL commit_rst_no_resp: got %0d expected 0", seen); end
        do_access(1'b0, 1'b0, 32'h0000_0024, 32'h0, rd, er, st, rc);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL commit_rst_no_write: got %h expected 0", rd); end
        do_access(1'b0, 1'b0, 32'h0000_0028, 32'h0, rd, er, st, rc);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL commit_rst_cleared: got %h expected 0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int st; int rc;
        int nresp; int c1; int c2; logic [31:0] d1; logic [31:0] d2; logic rdy;
        do_access(1'b0, 1'b1, 32'h0000_0030, 32'hA5A5_A5A5, rd, er, st, rc);
        do_access(1'b0, 1'b1, 32'h0000_0034, 32'h5A5A_5A5A, rd, er, st, rc);
        nresp = 0; c1 = -1; c2 = -1; d1 = 'x; d2 = 'x; rdy = 1'bx;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
        for (int c = 1; c <= 14; c++) begin
            #1;
            if (c == c1 + 1) rdy = bus2.req_ready_o;
            if (bus2.resp_valid_o) begin
                nresp++;
                if (nresp == 1) begin
                    c1 = c; d1 = bus2.resp_rdata_o;
                    drive(1'b0, 1'b1, 1'b0, 32'h0000_0034, 32'h0);
                end else if (nresp == 2) begin
                    c2 = c; d2 = bus2.resp_rdata_o;
                    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
            next_cycle();
        end
        vectors++; if (c1 !== 4 || d1 !== 32'hA5A5_A5A5) begin miscompares++; $display("[TB] FAIL b2b_first: got cyc %0d data %h expected 4 a5a5a5a5", c1, d1); end
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_idle_ready: got %b expected 1", rdy); end
        vectors++; if (c2 !== 8 || d2 !== 32'h5A5A_5A5A) begin miscompares++; $display("[TB] FAIL b2b_second: got cyc %0d data %h expected 8 5a5a5a5a", c2, d2); end
        vectors++; if (nresp !== 2) begin miscompares++; $display("[TB] FAIL b2b_resp_count: got %0d expected 2", nresp); end
    endtask

    // Scenario sequence
    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_store_load();
        test_zero_wait();
        test_errors();
        test_reset_mid_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
